instr_fetch_unit: RTL and testbench

//  Fetch side of the single-cycle control path: owns the PC, fetches instruction words from instruction

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, pulls instruction words from instruction memory
// over a req/ack handshake, holds them in the IR for decode/execute, and
// picks the next PC (sequential, branch or halt) when the instruction retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic [31:0] ExtImm,
  output logic [5:0]  OpCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [15:0] r_cnt;

  logic        w_fetch_done;
  logic        w_retire;
  logic [15:0] w_cnt_inc;
  logic [31:0] w_pc4;
  logic [31:0] w_offset;
  logic [31:0] w_branch_pc;

  // An ack only counts while a request is actually outstanding.
  assign w_fetch_done = (r_state == S_FETCH) && imem_ack;
  assign w_retire     = (r_state == S_ISSUE) && ir_ready;
  assign w_cnt_inc    = r_cnt + 16'd1;

  // Branch offset is in words; the shift drops ExtImm's top two bits and
  // all sums wrap modulo 2^32, which also makes negative offsets work.
  assign w_pc4       = r_pc + 32'd4;
  assign w_offset    = ExtImm << 2;
  assign w_branch_pc = w_pc4 + w_offset;

  // State register; reset aborts any fetch in flight.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: HALT and ERR are sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = S_ISSUE;
        end else if (w_cnt_inc == TIMEOUT_C) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          w_state_nxt = PCWre ? S_FETCH : S_HALT;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, IR and timeout counter: IR loads on ack, PC advances on retire.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_pc  <= RESET_PC;
      r_ir  <= 32'd0;
      r_cnt <= 16'd0;
    end else begin
      if (w_fetch_done) begin
        r_ir  <= imem_rdata;
        r_cnt <= 16'd0;
      end else if (r_state == S_FETCH) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_retire && PCWre) begin
        r_pc <= PCSrc ? w_branch_pc : w_pc4;
      end
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign ir_valid  = (r_state == S_ISSUE);
  assign halted    = (r_state == S_HALT);
  assign fetch_err = (r_state == S_ERR);

  assign OpCode = r_ir[31:26];
  assign rs     = r_ir[25:21];
  assign rt     = r_ir[20:16];
  assign rd     = r_ir[15:11];
  assign imm16  = r_ir[15:0];
  assign PC     = r_pc;
  assign PC4    = w_pc4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (default timeout and a short
// timeout of 4) share one stimulus stream and are both compared every cycle
// against a behavioural model; directed scenarios pin the model with literals.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO_A   = 255;
  localparam int          TO_B   = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        ack;
  logic [31:0] rdata;
  logic        ready;
  logic        pcwre;
  logic        pcsrc;
  logic [31:0] ext;

  logic        o_req[2];
  logic [31:0] o_addr[2];
  logic        o_valid[2];
  logic [5:0]  o_op[2];
  logic [4:0]  o_rs[2];
  logic [4:0]  o_rt[2];
  logic [4:0]  o_rd[2];
  logic [15:0] o_imm[2];
  logic [31:0] o_pc[2];
  logic [31:0] o_pc4[2];
  logic        o_halt[2];
  logic        o_err[2];

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO_A)) u_dut_a (
    .CLK(CLK), .Reset(rst_n),
    .imem_req(o_req[0]), .imem_addr(o_addr[0]), .imem_ack(ack), .imem_rdata(rdata),
    .ir_valid(o_valid[0]), .ir_ready(ready), .PCWre(pcwre), .PCSrc(pcsrc), .ExtImm(ext),
    .OpCode(o_op[0]), .rs(o_rs[0]), .rt(o_rt[0]), .rd(o_rd[0]), .imm16(o_imm[0]),
    .PC(o_pc[0]), .PC4(o_pc4[0]), .halted(o_halt[0]), .fetch_err(o_err[0])
  );

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO_B)) u_dut_b (
    .CLK(CLK), .Reset(rst_n),
    .imem_req(o_req[1]), .imem_addr(o_addr[1]), .imem_ack(ack), .imem_rdata(rdata),
    .ir_valid(o_valid[1]), .ir_ready(ready), .PCWre(pcwre), .PCSrc(pcsrc), .ExtImm(ext),
    .OpCode(o_op[1]), .rs(o_rs[1]), .rt(o_rt[1]), .rd(o_rd[1]), .imm16(o_imm[1]),
    .PC(o_pc[1]), .PC4(o_pc4[1]), .halted(o_halt[1]), .fetch_err(o_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each core should show after every clock edge.
  logic [31:0] m_pc[2];
  logic [31:0] m_ir[2];
  int          m_wait[2];
  bit          m_boot[2];
  bit          m_req[2];
  bit          m_val[2];
  bit          m_halt[2];
  bit          m_err[2];

  function automatic int limit(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] <= RST_PC; m_ir[k] <= 32'd0; m_wait[k] <= 0;
        m_boot[k] <= 1'b1; m_req[k] <= 1'b0; m_val[k] <= 1'b0;
        m_halt[k] <= 1'b0; m_err[k] <= 1'b0;
      end else if (m_boot[k]) begin
        m_boot[k] <= 1'b0;
        m_req[k]  <= 1'b1;
      end else if (m_req[k]) begin
        if (ack) begin
          m_ir[k] <= rdata; m_wait[k] <= 0; m_req[k] <= 1'b0; m_val[k] <= 1'b1;
        end else begin
          m_wait[k] <= m_wait[k] + 1;
          if (m_wait[k] + 1 == limit(k)) begin
            m_req[k] <= 1'b0; m_err[k] <= 1'b1;
          end
        end
      end else if (m_val[k] && ready) begin
        m_val[k] <= 1'b0;
        if (pcwre) begin
          m_pc[k]  <= pcsrc ? (m_pc[k] + 32'd4 + ext * 32'd4) : (m_pc[k] + 32'd4);
          m_req[k] <= 1'b1;
        end else begin
          m_halt[k] <= 1'b1;
        end
      end
    end
  end

  // Compare both instances with the model on every falling edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req%0d", k), o_req[k], m_req[k]);
        if (m_req[k]) chk($sformatf("addr%0d", k), o_addr[k], m_pc[k]);
        chk($sformatf("valid%0d", k), o_valid[k], m_val[k]);
        chk($sformatf("halted%0d", k), o_halt[k], m_halt[k]);
        chk($sformatf("err%0d", k), o_err[k], m_err[k]);
        chk($sformatf("pc%0d", k), o_pc[k], m_pc[k]);
        chk($sformatf("pc4_%0d", k), o_pc4[k], m_pc[k] + 32'd4);
        chk($sformatf("fields%0d", k),
            {o_op[k], o_rs[k], o_rt[k], o_imm[k]}, m_ir[k]);
        chk($sformatf("rd%0d", k), o_rd[k], m_ir[k][15:11]);
      end
    end
  end

  // Starts at a falling edge with core A in FETCH; ends one edge after retire.
  task automatic do_instr(input logic [31:0] word, input logic we, input logic src,
                          input logic [31:0] off);
    ack = 1'b1; rdata = word;
    @(negedge CLK);
    chk("issue_valid", o_valid[0], 1'b1);
    ack = 1'b0; ready = 1'b1; pcwre = we; pcsrc = src; ext = off;
    @(negedge CLK);
    ready = 1'b0; pcwre = 1'b1; pcsrc = 1'b0; ext = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; rdata = 32'd0; ready = 1'b0;
    pcwre = 1'b1; pcsrc = 1'b0; ext = 32'd0;
    @(negedge CLK);
    chk_on = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_req", o_req[0], 1'b0);
    chk("rst_valid", o_valid[0], 1'b0);
    chk("rst_pc", o_pc[0], RST_PC);
    chk("rst_err", o_err[1], 1'b0);

    // Zero-wait fetch of word 0, sequential retire.
    rst_n = 1'b1;
    @(negedge CLK);
    chk("first_req", o_req[0], 1'b1);
    chk("first_addr", o_addr[0], 32'd0);
    do_instr(32'h0000_0000, 1'b1, 1'b0, 32'd0);
    chk("seq_addr", o_addr[0], 32'd4);

    // Branches from PC=8: back by two words, then forward by three.
    do_instr(32'h8C22_0004, 1'b1, 1'b0, 32'd0);
    chk("pc8_addr", o_addr[0], 32'd8);
    do_instr(32'h1000_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("br_back", o_addr[0], 32'd4);
    do_instr(32'h0000_0000, 1'b1, 1'b0, 32'd0);
    do_instr(32'h1000_0003, 1'b1, 1'b1, 32'd3);
    chk("br_fwd", o_addr[0], 32'd24);

    // Five-cycle memory stall, then a three-cycle execute stall.
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", o_req[0], 1'b1);
      chk("stall_addr", o_addr[0], 32'd24);
      @(negedge CLK);
    end
    ack = 1'b1; rdata = 32'hAC64_1234;
    @(negedge CLK);
    ack = 1'b0;
    chk("to_err", o_err[1], 1'b1);
    chk("to_req", o_req[1], 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_op", o_op[0], 6'h2B);
      chk("hold_noreq", o_req[0], 1'b0);
      @(negedge CLK);
    end
    ready = 1'b1;
    @(negedge CLK);
    ready = 1'b0;
    chk("after_stall", o_addr[0], 32'd28);

    // Branch to 12, then a halt instruction there.
    do_instr(32'h1000_FFFB, 1'b1, 1'b1, 32'hFFFF_FFFB);
    chk("pc12_addr", o_addr[0], 32'd12);
    do_instr(32'hFC00_0000, 1'b0, 1'b0, 32'd0);
    chk("halt_flag", o_halt[0], 1'b1);
    chk("halt_pc", o_pc[0], 32'd12);
    ack = 1'b1; ready = 1'b1; pcsrc = 1'b1;
    repeat (2) @(negedge CLK);
    chk("halt_noreq", o_req[0], 1'b0);
    ack = 1'b0; ready = 1'b0; pcsrc = 1'b0;
    rst_n = 1'b0;
    @(negedge CLK);
    chk("unhalt_pc", o_pc[0], RST_PC);
    chk("unhalt_flag", o_halt[0], 1'b0);

    // Reset during FETCH with a simultaneous ack must not load IR.
    rst_n = 1'b1;
    @(negedge CLK);
    rst_n = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    chk("abort_valid", o_valid[0], 1'b0);
    chk("abort_op", o_op[0], 6'd0);
    rst_n = 1'b1; ack = 1'b0;
    @(negedge CLK);
    do_instr(32'h1000_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_addr", o_addr[0], 32'hFFFF_FFFC);
    do_instr(32'h0000_0000, 1'b1, 1'b0, 32'd0);
    chk("wrap_zero", o_addr[0], 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      ack   = $urandom_range(0, 1);
      rdata = $urandom;
      ready = $urandom_range(0, 1);
      pcwre = ($urandom_range(0, 9) != 0);
      pcsrc = $urandom_range(0, 1);
      ext   = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
